// File: rtl/gpu_cdb_pkg.sv
// Shared types for the CDB writeback stage: the buffered result entry and source index.
package gpu_cdb_pkg;

    localparam int CDB_NUM_THREADS = 8;
    localparam int CDB_DATA_WIDTH  = 32;
    localparam int CDB_DEPTH       = 4;

    typedef enum logic {
        SRC_ALU  = 1'b0,
        SRC_MULT = 1'b1
    } cdb_src_e;

    typedef struct packed {
        logic [2:0]                                 warp;
        logic [31:0]                                instr;
        logic                                       regwrite;
        logic [4:0]                                 dst;
        logic [1:0]                                 scbid;
        logic [CDB_NUM_THREADS-1:0]                 mask;
        logic [CDB_NUM_THREADS*CDB_DATA_WIDTH-1:0]  data;
    } cdb_entry_t;

endpackage

// File: rtl/cdb_fifo.sv
// Per-source result FIFO; almost_full is registered and asserts at DEPTH-1 entries.
module cdb_fifo import gpu_cdb_pkg::*; #(
    parameter int  DEPTH = CDB_DEPTH,
    parameter type T     = cdb_entry_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  T                         i_data,
    output T                         o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_almost_full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    T               r_mem [DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic [CW-1:0]  w_count_next;
    logic           r_almost_full;
    logic           w_push_ok;
    logic           w_pop_ok;

    assign o_full    = (r_count == CW'(DEPTH));
    assign w_pop_ok  = i_pop && (r_count != '0);
    // A full FIFO still accepts when its head leaves in the same cycle.
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    always_comb begin
        w_count_next = r_count;
        if (w_push_ok && !w_pop_ok) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_push_ok && w_pop_ok) begin
            w_count_next = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_almost_full <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count       <= w_count_next;
            r_almost_full <= (w_count_next >= CW'(DEPTH - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head        = r_mem[r_rd_ptr];
    assign o_count       = r_count;
    assign o_almost_full = r_almost_full;

endmodule

// File: rtl/cdb_writeback.sv
// CDB writeback: two source FIFOs, round-robin arbiter, registered broadcast and sticky overflow.
// Define CDB_BYPASS_EN to let an empty, winning source go straight to the output register.
module cdb_writeback import gpu_cdb_pkg::*; #(
    parameter int NUM_THREADS = CDB_NUM_THREADS,
    parameter int DATA_WIDTH  = CDB_DATA_WIDTH,
    parameter int DEPTH       = CDB_DEPTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              Valid_ALU_CDB,
    input  logic [2:0]                        WarpID_ALU_CDB,
    input  logic [31:0]                       Instr_ALU_CDB,
    input  logic                              RegWrite_ALU_CDB,
    input  logic [4:0]                        Dst_ALU_CDB,
    input  logic [1:0]                        ScbID_ALU_CDB,
    input  logic [NUM_THREADS-1:0]            ActiveMask_ALU_CDB,
    input  logic [NUM_THREADS*DATA_WIDTH-1:0] Dst_Data_ALU_CDB,
    input  logic                              Valid_MULT_CDB,
    input  logic [2:0]                        WarpID_MULT_CDB,
    input  logic [31:0]                       Instr_MULT_CDB,
    input  logic                              RegWrite_MULT_CDB,
    input  logic [4:0]                        Dst_MULT_CDB,
    input  logic [1:0]                        ScbID_MULT_CDB,
    input  logic [NUM_THREADS-1:0]            ActiveMask_MULT_CDB,
    input  logic [NUM_THREADS*DATA_WIDTH-1:0] Dst_Data_MULT_CDB,
    output logic                              Full_CDB_ALU,
    output logic                              Full_CDB_MULT,
    output logic                              Valid_CDB,
    output logic [2:0]                        WarpID_CDB,
    output logic [31:0]                       Instr_CDB,
    output logic                              RegWrite_CDB,
    output logic [4:0]                        Dst_CDB,
    output logic [NUM_THREADS-1:0]            ActiveMask_CDB,
    output logic [NUM_THREADS*DATA_WIDTH-1:0] Dst_Data_CDB,
    output logic                              Clear_Valid_CDB_Scb,
    output logic [2:0]                        Clear_WarpID_CDB_Scb,
    output logic [1:0]                        Clear_ScbID_CDB_Scb,
    output logic                              Overflow_CDB
);

    cdb_entry_t               w_in_alu;
    cdb_entry_t               w_in_mult;
    cdb_entry_t               w_head_alu;
    cdb_entry_t               w_head_mult;
    cdb_entry_t               w_out_next;
    cdb_entry_t               r_out;
    logic [$clog2(DEPTH):0]   w_count_alu;
    logic [$clog2(DEPTH):0]   w_count_mult;
    logic                     w_full_alu;
    logic                     w_full_mult;
    logic                     w_afull_alu;
    logic                     w_afull_mult;
    logic                     w_empty_alu;
    logic                     w_empty_mult;
    logic                     w_req_alu;
    logic                     w_req_mult;
    logic                     w_grant_valid;
    cdb_src_e                 w_grant;
    cdb_src_e                 r_last_grant;
    logic                     w_byp_alu;
    logic                     w_byp_mult;
    logic                     w_pop_alu;
    logic                     w_pop_mult;
    logic                     w_push_alu;
    logic                     w_push_mult;
    logic                     w_drop;
    logic                     r_valid;
    logic                     r_overflow;

    assign w_in_alu = '{warp: WarpID_ALU_CDB, instr: Instr_ALU_CDB, regwrite: RegWrite_ALU_CDB,
                        dst: Dst_ALU_CDB, scbid: ScbID_ALU_CDB, mask: ActiveMask_ALU_CDB,
                        data: Dst_Data_ALU_CDB};
    assign w_in_mult = '{warp: WarpID_MULT_CDB, instr: Instr_MULT_CDB, regwrite: RegWrite_MULT_CDB,
                         dst: Dst_MULT_CDB, scbid: ScbID_MULT_CDB, mask: ActiveMask_MULT_CDB,
                         data: Dst_Data_MULT_CDB};

    assign w_empty_alu  = (w_count_alu == '0);
    assign w_empty_mult = (w_count_mult == '0);

    always_comb begin
        w_req_alu  = !w_empty_alu;
        w_req_mult = !w_empty_mult;
`ifdef CDB_BYPASS_EN
        w_req_alu  = w_req_alu || Valid_ALU_CDB;
        w_req_mult = w_req_mult || Valid_MULT_CDB;
`endif
        w_grant = SRC_ALU;
        if (w_req_alu && w_req_mult) begin
            w_grant = (r_last_grant == SRC_ALU) ? SRC_MULT : SRC_ALU;
        end else if (w_req_mult) begin
            w_grant = SRC_MULT;
        end
        w_grant_valid = w_req_alu || w_req_mult;

        // A granted source with an empty FIFO can only be a bypass request.
        w_byp_alu   = w_grant_valid && (w_grant == SRC_ALU) && w_empty_alu;
        w_byp_mult  = w_grant_valid && (w_grant == SRC_MULT) && w_empty_mult;
        w_pop_alu   = w_grant_valid && (w_grant == SRC_ALU) && !w_empty_alu;
        w_pop_mult  = w_grant_valid && (w_grant == SRC_MULT) && !w_empty_mult;
        w_push_alu  = Valid_ALU_CDB && !w_byp_alu;
        w_push_mult = Valid_MULT_CDB && !w_byp_mult;

        w_out_next = r_out;
        if (w_grant_valid) begin
            if (w_grant == SRC_ALU) begin
                w_out_next = w_byp_alu ? w_in_alu : w_head_alu;
            end else begin
                w_out_next = w_byp_mult ? w_in_mult : w_head_mult;
            end
        end

        w_drop = (w_push_alu && w_full_alu && !w_pop_alu) ||
                 (w_push_mult && w_full_mult && !w_pop_mult);
    end

    cdb_fifo #(.DEPTH(DEPTH), .T(cdb_entry_t)) u_fifo_alu (
        .clk           (clk),
        .rst           (rst),
        .i_push        (w_push_alu),
        .i_pop         (w_pop_alu),
        .i_data        (w_in_alu),
        .o_head        (w_head_alu),
        .o_count       (w_count_alu),
        .o_full        (w_full_alu),
        .o_almost_full (w_afull_alu)
    );

    cdb_fifo #(.DEPTH(DEPTH), .T(cdb_entry_t)) u_fifo_mult (
        .clk           (clk),
        .rst           (rst),
        .i_push        (w_push_mult),
        .i_pop         (w_pop_mult),
        .i_data        (w_in_mult),
        .o_head        (w_head_mult),
        .o_count       (w_count_mult),
        .o_full        (w_full_mult),
        .o_almost_full (w_afull_mult)
    );

    // The pointer only moves when both sources actually competed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_out        <= '0;
            r_last_grant <= SRC_MULT;
            r_overflow   <= 1'b0;
        end else begin
            r_valid <= w_grant_valid;
            r_out   <= w_out_next;
            if (w_req_alu && w_req_mult) r_last_grant <= w_grant;
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    assign Full_CDB_ALU         = w_afull_alu;
    assign Full_CDB_MULT        = w_afull_mult;
    assign Valid_CDB            = r_valid;
    assign WarpID_CDB           = r_out.warp;
    assign Instr_CDB            = r_out.instr;
    assign RegWrite_CDB         = r_out.regwrite;
    assign Dst_CDB              = r_out.dst;
    assign ActiveMask_CDB       = r_out.mask;
    assign Dst_Data_CDB         = r_out.data;
    assign Clear_Valid_CDB_Scb  = r_valid;
    assign Clear_WarpID_CDB_Scb = r_out.warp;
    assign Clear_ScbID_CDB_Scb  = r_out.scbid;
    assign Overflow_CDB         = r_overflow;

endmodule

// File: tb/tb_cdb_writeback.sv
// Directed bench for cdb_writeback with a queue-based reference model checked every cycle.
module tb_cdb_writeback;
    import gpu_cdb_pkg::*;

    localparam int NT    = 8;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            Valid_ALU_CDB, Valid_MULT_CDB;
    logic [2:0]      WarpID_ALU_CDB, WarpID_MULT_CDB;
    logic [31:0]     Instr_ALU_CDB, Instr_MULT_CDB;
    logic            RegWrite_ALU_CDB, RegWrite_MULT_CDB;
    logic [4:0]      Dst_ALU_CDB, Dst_MULT_CDB;
    logic [1:0]      ScbID_ALU_CDB, ScbID_MULT_CDB;
    logic [NT-1:0]   ActiveMask_ALU_CDB, ActiveMask_MULT_CDB;
    logic [NT*DW-1:0] Dst_Data_ALU_CDB, Dst_Data_MULT_CDB;
    logic            Full_CDB_ALU, Full_CDB_MULT, Valid_CDB, RegWrite_CDB;
    logic [2:0]      WarpID_CDB, Clear_WarpID_CDB_Scb;
    logic [31:0]     Instr_CDB;
    logic [4:0]      Dst_CDB;
    logic [NT-1:0]   ActiveMask_CDB;
    logic [NT*DW-1:0] Dst_Data_CDB;
    logic            Clear_Valid_CDB_Scb, Overflow_CDB;
    logic [1:0]      Clear_ScbID_CDB_Scb;

    int checks   = 0;
    int failures = 0;
    bit started  = 1'b0;
    logic [31:0] seen[$];

    cdb_writeback #(.NUM_THREADS(NT), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .Valid_ALU_CDB(Valid_ALU_CDB), .WarpID_ALU_CDB(WarpID_ALU_CDB), .Instr_ALU_CDB(Instr_ALU_CDB),
        .RegWrite_ALU_CDB(RegWrite_ALU_CDB), .Dst_ALU_CDB(Dst_ALU_CDB), .ScbID_ALU_CDB(ScbID_ALU_CDB),
        .ActiveMask_ALU_CDB(ActiveMask_ALU_CDB), .Dst_Data_ALU_CDB(Dst_Data_ALU_CDB),
        .Valid_MULT_CDB(Valid_MULT_CDB), .WarpID_MULT_CDB(WarpID_MULT_CDB), .Instr_MULT_CDB(Instr_MULT_CDB),
        .RegWrite_MULT_CDB(RegWrite_MULT_CDB), .Dst_MULT_CDB(Dst_MULT_CDB), .ScbID_MULT_CDB(ScbID_MULT_CDB),
        .ActiveMask_MULT_CDB(ActiveMask_MULT_CDB), .Dst_Data_MULT_CDB(Dst_Data_MULT_CDB),
        .Full_CDB_ALU(Full_CDB_ALU), .Full_CDB_MULT(Full_CDB_MULT), .Valid_CDB(Valid_CDB),
        .WarpID_CDB(WarpID_CDB), .Instr_CDB(Instr_CDB), .RegWrite_CDB(RegWrite_CDB), .Dst_CDB(Dst_CDB),
        .ActiveMask_CDB(ActiveMask_CDB), .Dst_Data_CDB(Dst_Data_CDB),
        .Clear_Valid_CDB_Scb(Clear_Valid_CDB_Scb), .Clear_WarpID_CDB_Scb(Clear_WarpID_CDB_Scb),
        .Clear_ScbID_CDB_Scb(Clear_ScbID_CDB_Scb), .Overflow_CDB(Overflow_CDB)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one queue per source, results leave in round-robin order.
    cdb_entry_t qa[$];
    cdb_entry_t qm[$];
    cdb_entry_t m_out;
    bit         m_valid, m_ovf, m_last_alu;

    always @(posedge clk or posedge rst) begin : model
        cdb_entry_t ia, im;
        bit ra, rm, take_a, byp_a, byp_m;
        if (rst) begin
            qa.delete();
            qm.delete();
            m_out      = '0;
            m_valid    = 1'b0;
            m_ovf      = 1'b0;
            m_last_alu = 1'b0;
        end else begin
            ia.warp = WarpID_ALU_CDB;  ia.instr = Instr_ALU_CDB;  ia.regwrite = RegWrite_ALU_CDB;
            ia.dst  = Dst_ALU_CDB;     ia.scbid = ScbID_ALU_CDB;  ia.mask = ActiveMask_ALU_CDB;
            ia.data = Dst_Data_ALU_CDB;
            im.warp = WarpID_MULT_CDB; im.instr = Instr_MULT_CDB; im.regwrite = RegWrite_MULT_CDB;
            im.dst  = Dst_MULT_CDB;    im.scbid = ScbID_MULT_CDB; im.mask = ActiveMask_MULT_CDB;
            im.data = Dst_Data_MULT_CDB;
            ra = (qa.size() != 0);
            rm = (qm.size() != 0);
`ifdef CDB_BYPASS_EN
            ra = ra || Valid_ALU_CDB;
            rm = rm || Valid_MULT_CDB;
`endif
            byp_a = 1'b0;
            byp_m = 1'b0;
            if (ra && rm) begin
                take_a     = !m_last_alu;
                m_last_alu = take_a;
            end else begin
                take_a = ra;
            end
            m_valid = ra || rm;
            if (m_valid) begin
                if (take_a) begin
                    if (qa.size() == 0) begin m_out = ia; byp_a = 1'b1; end
                    else m_out = qa.pop_front();
                end else begin
                    if (qm.size() == 0) begin m_out = im; byp_m = 1'b1; end
                    else m_out = qm.pop_front();
                end
            end
            if (Valid_ALU_CDB && !byp_a) begin
                if (qa.size() < DEPTH) qa.push_back(ia);
                else m_ovf = 1'b1;
            end
            if (Valid_MULT_CDB && !byp_m) begin
                if (qm.size() < DEPTH) qm.push_back(im);
                else m_ovf = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("valid", Valid_CDB, m_valid);
            chk("clear_valid", Clear_Valid_CDB_Scb, m_valid);
            chk("warp", WarpID_CDB, m_out.warp);
            chk("clear_warp", Clear_WarpID_CDB_Scb, m_out.warp);
            chk("clear_scbid", Clear_ScbID_CDB_Scb, m_out.scbid);
            chk("instr", Instr_CDB, m_out.instr);
            chk("regwrite", RegWrite_CDB, m_out.regwrite);
            chk("dst", Dst_CDB, m_out.dst);
            chk("mask", ActiveMask_CDB, m_out.mask);
            chk("data", Dst_Data_CDB, m_out.data);
            chk("full_alu", Full_CDB_ALU, qa.size() >= DEPTH - 1);
            chk("full_mult", Full_CDB_MULT, qm.size() >= DEPTH - 1);
            chk("overflow", Overflow_CDB, m_ovf);
            if (Valid_CDB) seen.push_back(Instr_CDB);
        end
    end

    task automatic load(input bit is_mult, input logic [31:0] id);
        logic [NT*DW-1:0] d;
        for (int l = 0; l < NT; l++) d[l*DW +: DW] = id * 32'h9E37_79B9 + l;
        if (is_mult) begin
            WarpID_MULT_CDB = id[2:0]; Instr_MULT_CDB = id; RegWrite_MULT_CDB = id[0];
            Dst_MULT_CDB = id[4:0] ^ 5'h1f; ScbID_MULT_CDB = id[1:0];
            ActiveMask_MULT_CDB = id[7:0] ^ 8'hA5; Dst_Data_MULT_CDB = d;
        end else begin
            WarpID_ALU_CDB = id[2:0]; Instr_ALU_CDB = id; RegWrite_ALU_CDB = id[0];
            Dst_ALU_CDB = id[4:0] ^ 5'h1f; ScbID_ALU_CDB = id[1:0];
            ActiveMask_ALU_CDB = id[7:0] ^ 8'hA5; Dst_Data_ALU_CDB = d;
        end
    endtask

    task automatic push_cycle(input bit va, input bit vm);
        Valid_ALU_CDB  = va;
        Valid_MULT_CDB = vm;
        @(negedge clk);
        Valid_ALU_CDB  = 1'b0;
        Valid_MULT_CDB = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        logic [31:0] exp_id;
        bit found;
        Valid_ALU_CDB = 1'b0;
        Valid_MULT_CDB = 1'b0;
        load(1'b0, 32'h0);
        load(1'b1, 32'h0);
        #1 rst = 1'b1;
        started = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_valid", Valid_CDB, 1'b0);
        chk("rst_overflow", Overflow_CDB, 1'b0);
        chk("rst_full_alu", Full_CDB_ALU, 1'b0);
        chk("rst_full_mult", Full_CDB_MULT, 1'b0);
        chk("rst_instr", Instr_CDB, 32'h0);

        // Single ALU result.
        load(1'b0, 32'h0000_0042);
        WarpID_ALU_CDB = 3'd3;
        Dst_ALU_CDB = 5'd5;
        Dst_Data_ALU_CDB = {NT{32'h11}};
        push_cycle(1'b1, 1'b0);
`ifndef CDB_BYPASS_EN
        #1 chk("lat_early_valid", Valid_CDB, 1'b0);
        idle(1);
`endif
        #1;
        chk("single_valid", Valid_CDB, 1'b1);
        chk("single_warp", WarpID_CDB, 3'd3);
        chk("single_dst", Dst_CDB, 5'd5);
        chk("single_data", Dst_Data_CDB, {NT{32'h11}});
        chk("single_clear_valid", Clear_Valid_CDB_Scb, 1'b1);
        chk("single_clear_warp", Clear_WarpID_CDB_Scb, 3'd3);
        idle(3);

        // Both sources valid for four cycles: strict alternation, nothing lost.
        #1 seen.delete();
        for (int i = 0; i < 4; i++) begin
            load(1'b0, 32'h100 + i);
            load(1'b1, 32'h200 + i);
            push_cycle(1'b1, 1'b1);
        end
        idle(8);
        #1;
        chk("alt_count", seen.size(), 8);
        for (int k = 0; k < 8 && k < seen.size(); k++) begin
            exp_id = ((k % 2) ? 32'h200 : 32'h100) + k / 2;
            chk("alt_order", seen[k], exp_id);
        end
        chk("alt_overflow", Overflow_CDB, 1'b0);

        // Twelve cycles of both sources: FIFOs fill, alternate drops, overflow sticks.
        do_reset();
        seen.delete();
        for (int i = 0; i < 12; i++) begin
            load(1'b0, 32'h300 + i);
            load(1'b1, 32'h400 + i);
            push_cycle(1'b1, 1'b1);
`ifndef CDB_BYPASS_EN
            if (i == 3) begin
                #1;
                chk("full_alu_at2", Full_CDB_ALU, 1'b0);
                chk("full_mult_at3", Full_CDB_MULT, 1'b1);
            end
            if (i == 4) begin
                #1 chk("full_alu_at3", Full_CDB_ALU, 1'b1);
            end
`endif
        end
        idle(25);
        #1;
        chk("ovf_sticky", Overflow_CDB, 1'b1);
        chk("ovf_full_fell", Full_CDB_ALU, 1'b0);
`ifndef CDB_BYPASS_EN
        chk("ovf_results", seen.size(), 19);
        found = 1'b0;
        foreach (seen[k]) if (seen[k] == 32'h407 || seen[k] == 32'h308) found = 1'b1;
        chk("ovf_dropped_absent", found, 1'b0);
`endif

        // Reset while entries are buffered and the output is busy.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            load(1'b0, 32'h500 + i);
            load(1'b1, 32'h600 + i);
            push_cycle(1'b1, 1'b1);
        end
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", Valid_CDB, 1'b0);
        chk("arst_clear_valid", Clear_Valid_CDB_Scb, 1'b0);
        chk("arst_instr", Instr_CDB, 32'h0);
        chk("arst_data", Dst_Data_CDB, '0);
        chk("arst_full_mult", Full_CDB_MULT, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1 seen.delete();
        idle(5);
        #1 chk("arst_no_stale", seen.size(), 0);
        load(1'b0, 32'h700);
        load(1'b1, 32'h800);
        push_cycle(1'b1, 1'b1);
        idle(4);
        #1;
        chk("arst_restart_count", seen.size(), 2);
        if (seen.size() >= 2) begin
            chk("arst_restart_first", seen[0], 32'h700);
            chk("arst_restart_second", seen[1], 32'h800);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cdb_writeback.md
# cdb_writeback

Common Data Bus writeback stage: receives completed results from the ALU and the multiplier, buffers each source in its own FIFO, and drives one result per cycle onto the CDB. The CDB feeds register-file writeback and scoreboard release. It sits after the execution units and closes the OC→execute→CDB loop. Backpressure reaches the operand collector through per-source full flags.

## Interface
- `NUM_THREADS`, 8: lanes per warp.
- `DATA_WIDTH`, 32: bits per lane.
- `DEPTH`, 4: entries per source FIFO; must be a power of two, at least 2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `Valid_ALU_CDB`, `Valid_MULT_CDB`  in  1 each  result present this cycle.
- `WarpID_{ALU,MULT}_CDB`  in  3  warp ID.
- `Instr_{ALU,MULT}_CDB`  in  32  instruction word.
- `RegWrite_{ALU,MULT}_CDB`  in  1  writes a register.
- `Dst_{ALU,MULT}_CDB`  in  5  destination register.
- `ScbID_{ALU,MULT}_CDB`  in  2  scoreboard entry to release.
- `ActiveMask_{ALU,MULT}_CDB`  in  8  lane mask.
- `Dst_Data_{ALU,MULT}_CDB`  in  NUM_THREADS*DATA_WIDTH  lane data.
- `Full_CDB_ALU`, `Full_CDB_MULT`  out  1 each  FIFO cannot accept an entry next cycle.
- `Valid_CDB`, `WarpID_CDB`, `Instr_CDB`, `RegWrite_CDB`, `Dst_CDB`, `ActiveMask_CDB`, `Dst_Data_CDB`  out  matching widths  registered broadcast.
- `Clear_Valid_CDB_Scb`  out  1  release scoreboard entry.
- `Clear_WarpID_CDB_Scb`  out  3  warp of the released entry.
- `Clear_ScbID_CDB_Scb`  out  2  ID of the released entry.
- `Overflow_CDB`  out  1  sticky error flag.

## Operation
- Each source has its own FIFO, `DEPTH` entries deep.
  - A push occurs when the source's Valid is high.
  - If the FIFO is full and is not being popped in the same cycle, the entry is dropped and `Overflow_CDB` sets. Only reset clears `Overflow_CDB`.
- Arbitration is round-robin between the two non-empty FIFOs.
  - A 1-bit last-grant register picks the source that did not win last time.
  - If only one FIFO is non-empty, that FIFO is granted and the pointer does not move.
  - After reset the pointer favours the ALU.
- The granted head is popped and loaded into the output register.
- The output register drives all CDB outputs for exactly one cycle. With no grant, `Valid_CDB` goes to 0 and data holds its previous value.
- `Clear_Valid_CDB_Scb` equals `Valid_CDB`. The Clear WarpID and ScbID come from the same output entry.
- FIFO count width is clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Full flag: `Full_CDB_x` = (count ≥ DEPTH−1), registered. One slot of slack covers the single-cycle OC issue delay.
- Reset mid-operation flushes both FIFOs. All buffered results are lost, and the OC/scoreboard must also be reset.
- Reset values: every output 0, FIFOs empty, round-robin pointer on ALU.

## Timing
- Latency without the bypass build option: result at input edge N is stored in the FIFO at N. It can be granted into the output register at N+1, so `Valid_CDB` is high during cycle N+2 at the earliest.
- Throughput: one CDB result per cycle. With both sources pushing every cycle, each source is drained at 1/2 rate.
- A push and a pop on the same FIFO in the same cycle are both performed; the count is unchanged.
- A push to an empty FIFO cannot be granted in the same cycle.

## Configuration
- `CDB_BYPASS_EN`, defined: when a source's FIFO is empty, its input is valid, and it would win arbitration, the entry goes straight into the output register. No FIFO write occurs, and `Valid_CDB` is high in cycle N+1.
  - Input is valid at N; the other FIFO is empty or loses round-robin.
- `CDB_BYPASS_EN`, undefined: every entry passes through its FIFO, with the 2-cycle minimum latency above.

## Structure
- Shared package `gpu_cdb_pkg`:
  - `cdb_entry_t` packed struct: warp, instr, regwrite, dst, scbid, mask, data.
  - Source-index enum `SRC_ALU` / `SRC_MULT`.
- Sub-module `cdb_fifo`, parameterized by DEPTH and entry type, instantiated twice. It provides push, pop, head, count, and full/almost-full.
- Arbiter, output register and overflow flag live in the top module.

## Test plan
- Single ALU result, warp 3, Dst 5, data 0x11 in every lane, after reset.
  - Without bypass: `Valid_CDB` high at N+2 with identical fields, plus `Clear_Valid_CDB_Scb`=1 and Clear WarpID=3.
  - With bypass: same, at N+1.
- ALU and MULT both valid for 4 consecutive cycles: CDB sequence alternates ALU, MULT, ALU, MULT, …; 8 results with none lost; `Overflow_CDB` stays 0.
- ALU pushes 3 back-to-back with MULT busy (DEPTH=4, bypass off): `Full_CDB_ALU` rises after the 3rd push is counted, and falls once the count drops to ≤2.
- Force 5 ALU pushes while the CDB is starved by continuous MULT pushes:
  - `Overflow_CDB` sets and stays set.
  - The dropped entry never appears on the CDB.
- Assert `rst` while both FIFOs hold 2 entries:
  - All outputs are 0 asynchronously.
  - After release there is no `Valid_CDB` until a new push arrives.
  - The pointer restarts on ALU.
